// File: rtl/pcileech_ft601_devemu.sv
// FT601 245-synchronous-FIFO device emulator: drives the chip-side pads (RXF_N/TXE_N,
// read data) and exposes the USB host side as two valid/ready word streams.
module pcileech_ft601_devemu #(
    parameter int unsigned RX_DEPTH_LOG2 = 4,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_LATENCY    = 3,
    parameter int unsigned TXE_MARGIN    = 2,
    parameter int unsigned TX_BURST_MAX  = 0,
    parameter int unsigned TX_GAP        = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ft_rxf_n,
    output logic        ft_txe_n,
    input  logic        ft_oe_n,
    input  logic        ft_rd_n,
    input  logic        ft_wr_n,
    input  logic [31:0] ft_data_i,
    input  logic [3:0]  ft_be_i,
    output logic [31:0] ft_data_o,
    output logic [3:0]  ft_be_o,
    output logic        ft_data_oe,
    input  logic [31:0] host_din,
    input  logic        host_din_valid,
    output logic        host_din_ready,
    output logic [31:0] host_dout,
    output logic        host_dout_valid,
    input  logic        host_dout_ready,
    output logic [15:0] tx_overflow_cnt,
    output logic [1:0]  err_flags
);

    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int unsigned RXC_W    = RX_DEPTH_LOG2 + 1;
    localparam int unsigned TXC_W    = TX_DEPTH_LOG2 + 1;
    localparam int unsigned LAT_W    = $clog2(RX_LATENCY + 2);
    localparam int unsigned GAP_W    = $clog2(TX_GAP + 2);
    localparam int unsigned BURST_W  = $clog2(TX_BURST_MAX + 2);

    typedef enum logic [1:0] {
        ST_RX_EMPTY,
        ST_RX_HOLD,
        ST_RX_AVAIL
    } rx_state_t;

    typedef enum logic {
        ST_TX_OPEN,
        ST_TX_GAP
    } tx_state_t;

    // RX path: host -> pads
    logic [31:0]              rx_mem_q [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d;
    logic [RX_DEPTH_LOG2-1:0] rx_rptr_q, rx_rptr_d;
    logic [RXC_W-1:0]         rx_cnt_q, rx_cnt_d;
    logic                     rx_ready_q, rx_ready_d;
    logic [LAT_W-1:0]         rx_lat_q, rx_lat_d;
    logic                     rxf_n_q, rxf_n_d;
    rx_state_t                rx_state_q, rx_state_d;
    logic                     rx_push, rx_pop;

    // TX path: pads -> host
    logic [31:0]              tx_mem_q [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d;
    logic [TX_DEPTH_LOG2-1:0] tx_rptr_q, tx_rptr_d;
    logic [TXC_W-1:0]         tx_cnt_q, tx_cnt_d;
    logic [TXC_W-1:0]         tx_free_d;
    logic [GAP_W-1:0]         tx_gap_q, tx_gap_d;
    logic [BURST_W-1:0]       tx_burst_q, tx_burst_d;
    logic                     txe_n_q, txe_n_d;
    tx_state_t                tx_state_q, tx_state_d;
    logic [15:0]              tx_ovf_q, tx_ovf_d;
    logic [1:0]               err_q, err_d;
    logic                     tx_wr, tx_full, tx_pop, tx_store, tx_drop, tx_room_lo;

    always_comb begin
        rx_push    = host_din_valid & rx_ready_q;
        rx_pop     = ~ft_oe_n & ~ft_rd_n & ~rxf_n_q;
        rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_cnt_d   = rx_cnt_q + RXC_W'(rx_push) - RXC_W'(rx_pop);
        rx_ready_d = (rx_cnt_d != RXC_W'(RX_DEPTH));
        rx_state_d = rx_state_q;
        rx_lat_d   = rx_lat_q;
        rxf_n_d    = rxf_n_q;
        // Decisions use the post-edge count so RXF_N is high before the FIFO is empty
        case (rx_state_q)
            ST_RX_EMPTY: begin
                if (rx_cnt_d != '0) begin
                    if (RX_LATENCY == 0) begin
                        rx_state_d = ST_RX_AVAIL;
                        rxf_n_d    = 1'b0;
                    end else begin
                        rx_state_d = ST_RX_HOLD;
                        rx_lat_d   = LAT_W'(RX_LATENCY);
                    end
                end
            end
            ST_RX_HOLD: begin
                rx_lat_d = rx_lat_q - 1'b1;
                if (rx_lat_q == LAT_W'(1)) begin
                    rx_state_d = ST_RX_AVAIL;
                    rxf_n_d    = 1'b0;
                end
            end
            ST_RX_AVAIL: begin
                if (rx_cnt_d == '0) begin
                    rx_state_d = ST_RX_EMPTY;
                    rxf_n_d    = 1'b1;
                end
            end
            default: begin
                rx_state_d = ST_RX_EMPTY;
                rxf_n_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_wr      = ~ft_wr_n;
        tx_full    = (tx_cnt_q == TXC_W'(TX_DEPTH));
        tx_pop     = (tx_cnt_q != '0) & host_dout_ready;
        // A full FIFO still takes the write when the host frees a slot on the same edge
        tx_store   = tx_wr & (~tx_full | tx_pop);
        tx_drop    = tx_wr & tx_full & ~tx_pop;
        tx_wptr_d  = tx_store ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d  = tx_pop   ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_cnt_d   = tx_cnt_q + TXC_W'(tx_store) - TXC_W'(tx_pop);
        tx_free_d  = TXC_W'(TX_DEPTH) - tx_cnt_d;
        tx_room_lo = (32'(tx_free_d) <= TXE_MARGIN);
        tx_ovf_d   = tx_ovf_q;
        if (tx_drop && (tx_ovf_q != 16'hFFFF)) begin
            tx_ovf_d = tx_ovf_q + 16'd1;
        end
        err_d      = err_q | {tx_wr & (ft_be_i != 4'hF), ~ft_oe_n & tx_wr};
        tx_state_d = tx_state_q;
        tx_gap_d   = tx_gap_q;
        tx_burst_d = tx_burst_q;
        txe_n_d    = txe_n_q;
        case (tx_state_q)
            ST_TX_OPEN: begin
                txe_n_d = tx_room_lo;
                if (tx_store) begin
                    tx_burst_d = tx_burst_q + 1'b1;
                    if ((TX_BURST_MAX != 0) && (tx_burst_d == BURST_W'(TX_BURST_MAX))) begin
                        tx_state_d = ST_TX_GAP;
                        tx_burst_d = '0;
                        tx_gap_d   = GAP_W'(TX_GAP);
                        txe_n_d    = 1'b1;
                    end
                end
            end
            ST_TX_GAP: begin
                txe_n_d  = 1'b1;
                tx_gap_d = tx_gap_q - 1'b1;
                if (tx_gap_q == GAP_W'(1)) begin
                    tx_state_d = ST_TX_OPEN;
                    txe_n_d    = tx_room_lo;
                end
            end
            default: begin
                tx_state_d = ST_TX_OPEN;
                txe_n_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= ST_RX_EMPTY;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_ready_q <= 1'b0;
            rx_lat_q   <= '0;
            rxf_n_q    <= 1'b1;
            tx_state_q <= ST_TX_OPEN;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_gap_q   <= '0;
            tx_burst_q <= '0;
            txe_n_q    <= 1'b1;
            tx_ovf_q   <= '0;
            err_q      <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_ready_q <= rx_ready_d;
            rx_lat_q   <= rx_lat_d;
            rxf_n_q    <= rxf_n_d;
            tx_state_q <= tx_state_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_gap_q   <= tx_gap_d;
            tx_burst_q <= tx_burst_d;
            txe_n_q    <= txe_n_d;
            tx_ovf_q   <= tx_ovf_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= host_din;
        end
        if (tx_store) begin
            tx_mem_q[tx_wptr_q] <= ft_data_i;
        end
    end

    assign ft_rxf_n        = rxf_n_q;
    assign ft_txe_n        = txe_n_q;
    assign ft_data_o       = rx_mem_q[rx_rptr_q];
    assign ft_be_o         = 4'hF;
    assign ft_data_oe      = ~ft_oe_n & ~rst;
    assign host_din_ready  = rx_ready_q;
    assign host_dout       = tx_mem_q[tx_rptr_q];
    assign host_dout_valid = (tx_cnt_q != '0);
    assign tx_overflow_cnt = tx_ovf_q;
    assign err_flags       = err_q;

endmodule

// File: tb/tb_pcileech_ft601_devemu.sv
// Self-checking bench for pcileech_ft601_devemu: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pcileech_ft601_devemu;

    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam int RXL = 3;
    localparam int TXM = 2;
    localparam int TXB = 4;
    localparam int TXG = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ft_rxf_n, ft_txe_n;
    logic        ft_oe_n = 1'b1, ft_rd_n = 1'b1, ft_wr_n = 1'b1;
    logic [31:0] ft_data_i = '0;
    logic [3:0]  ft_be_i = 4'hF;
    logic [31:0] ft_data_o;
    logic [3:0]  ft_be_o;
    logic        ft_data_oe;
    logic [31:0] host_din = '0;
    logic        host_din_valid = 1'b0;
    logic        host_din_ready;
    logic [31:0] host_dout;
    logic        host_dout_valid;
    logic        host_dout_ready = 1'b0;
    logic [15:0] tx_overflow_cnt;
    logic [1:0]  err_flags;

    pcileech_ft601_devemu #(
        .RX_DEPTH_LOG2(4),
        .TX_DEPTH_LOG2(4),
        .RX_LATENCY   (RXL),
        .TXE_MARGIN   (TXM),
        .TX_BURST_MAX (TXB),
        .TX_GAP       (TXG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ft_rxf_n       (ft_rxf_n),
        .ft_txe_n       (ft_txe_n),
        .ft_oe_n        (ft_oe_n),
        .ft_rd_n        (ft_rd_n),
        .ft_wr_n        (ft_wr_n),
        .ft_data_i      (ft_data_i),
        .ft_be_i        (ft_be_i),
        .ft_data_o      (ft_data_o),
        .ft_be_o        (ft_be_o),
        .ft_data_oe     (ft_data_oe),
        .host_din       (host_din),
        .host_din_valid (host_din_valid),
        .host_din_ready (host_din_ready),
        .host_dout      (host_dout),
        .host_dout_valid(host_dout_valid),
        .host_dout_ready(host_dout_ready),
        .tx_overflow_cnt(tx_overflow_cnt),
        .err_flags      (err_flags)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: plain queues plus timestamps of when things happened
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    logic [31:0] got_q[$];
    bit          m_rxf = 1'b1, m_txe = 1'b1, m_rdy = 1'b0;
    int          m_ovf = 0;
    logic [1:0]  m_err = '0;
    int          m_burst = 0;
    longint      m_cyc = 0, m_gap_end = -1, m_ne_at = 0;

    task automatic m_reset();
        rxq.delete();
        txq.delete();
        m_rxf     = 1'b1;
        m_txe     = 1'b1;
        m_rdy     = 1'b0;
        m_ovf     = 0;
        m_err     = '0;
        m_burst   = 0;
        m_gap_end = -1;
    endtask

    task automatic m_step();
        bit rxpop, rxpush, was_empty, txpop, txstore, txwr;
        m_cyc++;
        rxpop     = !ft_oe_n && !ft_rd_n && !m_rxf;
        rxpush    = host_din_valid && m_rdy;
        was_empty = (rxq.size() == 0);
        if (rxpop) void'(rxq.pop_front());
        if (rxpush) rxq.push_back(host_din);
        if (was_empty && rxq.size() != 0) m_ne_at = m_cyc;
        m_rxf = !(rxq.size() != 0 && (m_cyc - m_ne_at) >= RXL);
        m_rdy = (rxq.size() < RXD);

        txwr    = !ft_wr_n;
        txpop   = (txq.size() != 0) && host_dout_ready;
        txstore = txwr && (txq.size() < TXD || txpop);
        if (txpop) void'(txq.pop_front());
        if (txstore) txq.push_back(ft_data_i);
        if (txwr && !txstore && m_ovf != 16'hFFFF) m_ovf++;
        if (txwr && ft_be_i != 4'hF) m_err[1] = 1'b1;
        if (txwr && !ft_oe_n) m_err[0] = 1'b1;
        if (txstore && m_cyc > m_gap_end) begin
            m_burst++;
            if (TXB != 0 && m_burst == TXB) begin
                m_burst   = 0;
                m_gap_end = m_cyc + TXG;
            end
        end
        m_txe = (m_cyc < m_gap_end) || ((TXD - int'(txq.size())) <= TXM);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) m_reset();
        else m_step();
    end

    // Compare process: all outputs against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_rxf_n", ft_rxf_n, 1);
            check("rst_txe_n", ft_txe_n, 1);
            check("rst_data_oe", ft_data_oe, 0);
            check("rst_din_ready", host_din_ready, 0);
            check("rst_dout_valid", host_dout_valid, 0);
            check("rst_ovf", tx_overflow_cnt, 0);
            check("rst_err", err_flags, 0);
        end else begin
            check("rxf_n", ft_rxf_n, m_rxf);
            check("txe_n", ft_txe_n, m_txe);
            check("din_ready", host_din_ready, m_rdy);
            check("dout_valid", host_dout_valid, txq.size() != 0);
            if (txq.size() != 0) check("dout", host_dout, txq[0]);
            if (rxq.size() != 0) check("data_o", ft_data_o, rxq[0]);
            check("data_oe", ft_data_oe, !ft_oe_n);
            if (!ft_oe_n) check("be_o", ft_be_o, 4'hF);
            check("ovf", tx_overflow_cnt, m_ovf);
            check("err", err_flags, m_err);
            if (host_dout_valid && host_dout_ready) got_q.push_back(host_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ft_oe_n         = 1'b1;
        ft_rd_n         = 1'b1;
        ft_wr_n         = 1'b1;
        ft_be_i         = 4'hF;
        host_din_valid  = 1'b0;
        host_dout_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] w1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    int          n_wr, run, runs, p;

    initial begin
        // 1) RX latency and in-order reads
        do_reset();
        check("t1_err_clear", err_flags, 2'b00);
        tick();
        check("t1_ready", host_din_ready, 1);
        for (int k = 0; k < 4; k++) begin
            host_din_valid = 1'b1;
            host_din       = w1[k];
            tick();
            check("t1_rxf_lat", ft_rxf_n, (k < 3) ? 1 : 0);
        end
        host_din_valid = 1'b0;
        ft_oe_n        = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t1_rd_data", ft_data_o, w1[k]);
            check("t1_rxf_low", ft_rxf_n, 0);
            ft_rd_n = 1'b0;
            tick();
        end
        check("t1_rxf_after", ft_rxf_n, 1);
        tick();
        tick();
        idle_inputs();
        check("t1_no_err", err_flags, 2'b00);

        // 2) 20 controller writes drained by the host
        do_reset();
        tick();
        host_dout_ready = 1'b1;
        got_q.delete();
        n_wr = 0;
        for (int c = 0; c < 200 && n_wr < 20; c++) begin
            if (!ft_txe_n) begin
                ft_wr_n   = 1'b0;
                ft_data_i = 32'hA5A50000 + 32'(n_wr);
                n_wr++;
            end else begin
                ft_wr_n = 1'b1;
            end
            tick();
        end
        ft_wr_n = 1'b1;
        check("t2_written", n_wr, 20);
        for (int c = 0; c < 4; c++) tick();
        check("t2_count", got_q.size(), 20);
        for (int i = 0; i < 20 && i < got_q.size(); i++) check("t2_word", got_q[i], 32'hA5A50000 + 32'(i));
        check("t2_ovf", tx_overflow_cnt, 0);

        // 3) Fill with no host drain: TXE_N margin and overflow count
        do_reset();
        ft_wr_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ft_data_i = 32'hB0000000 + 32'(k - 1);
            tick();
            if (k == 13) check("t3_txe_13", ft_txe_n, 0);
            if (k == 14) check("t3_txe_14", ft_txe_n, 1);
        end
        ft_wr_n = 1'b1;
        check("t3_ovf", tx_overflow_cnt, 4);
        got_q.delete();
        host_dout_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check("t3_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) check("t3_word", got_q[i], 32'hB0000000 + 32'(i));

        // 4) Forced TXE_N gaps after every TXB accepted words
        do_reset();
        tick();
        host_dout_ready = 1'b1;
        run  = 0;
        runs = 0;
        for (int c = 0; c < 60; c++) begin
            ft_wr_n   = ft_txe_n;
            ft_data_i = 32'hC0DE0000 + 32'(c);
            tick();
            if (ft_txe_n) run++;
            else if (run != 0) begin
                check("t4_gap_len", run, TXG);
                runs++;
                run = 0;
            end
        end
        ft_wr_n = 1'b1;
        check("t4_gap_seen", runs >= 3, 1);

        // 5) Sticky error flags
        do_reset();
        tick();
        ft_oe_n   = 1'b0;
        ft_wr_n   = 1'b0;
        ft_data_i = 32'h0E0E0001;
        tick();
        check("t5_err0", err_flags, 2'b01);
        ft_oe_n   = 1'b1;
        ft_data_i = 32'h0E0E0003;
        ft_be_i   = 4'h3;
        tick();
        ft_wr_n = 1'b1;
        ft_be_i = 4'hF;
        check("t5_err1", err_flags, 2'b11);
        got_q.delete();
        host_dout_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("t5_count", got_q.size(), 2);
        if (got_q.size() >= 2) check("t5_badbe_word", got_q[1], 32'h0E0E0003);
        check("t5_sticky", err_flags, 2'b11);

        // 6) Reset in the middle of an RX burst
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            host_din_valid = 1'b1;
            host_din       = 32'h66660000 + 32'(k);
            tick();
        end
        host_din_valid = 1'b0;
        tick();
        check("t6_rxf_low", ft_rxf_n, 0);
        ft_oe_n = 1'b0;
        ft_rd_n = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t6_oe_async", ft_data_oe, 0);
        check("t6_rxf_rst", ft_rxf_n, 1);
        check("t6_txe_rst", ft_txe_n, 1);
        check("t6_rdy_rst", host_din_ready, 0);
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_rdy_after", host_din_ready, 1);
        check("t6_dout_valid", host_dout_valid, 0);
        for (int c = 0; c < 5; c++) tick();
        check("t6_no_stale", ft_rxf_n, 1);

        // Randomized traffic in three mixes, with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            p = c / 1000;
            if (c == 1500) do_reset();
            host_din_valid  = ($urandom_range(0, 1) == 1);
            host_din        = $urandom;
            ft_oe_n         = (p == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ft_rd_n         = ($urandom_range(0, 2) == 0);
            ft_wr_n         = (p == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
            ft_be_i         = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
            ft_data_i       = $urandom;
            host_dout_ready = (p == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

endmodule
